// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch stage: issue-queue selects, sizing and
// the opcode classifier used by the dispatcher.
package dispatch_pkg;

  localparam int IQ_DEPTH  = 8;
  localparam int CW        = 4;
  localparam int FLUSH_CYC = 2;
  localparam int FLUSH_CW  = 2;

  localparam logic [1:0] INTALU = 2'b00;
  localparam logic [1:0] FPALU  = 2'b01;
  localparam logic [1:0] AGU    = 2'b10;

  // opcode[6:5] == 2'b10 marks FP ops; opcode[6]==0 && opcode[4]==0 marks memory ops
  localparam logic [1:0] OPC_FP_TOP = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  function automatic logic [1:0] classify_op(input logic [6:0] opcode);
    if (opcode[6:5] == OPC_FP_TOP) begin
      return FPALU;
    end else if (!opcode[6] && !opcode[4]) begin
      return AGU;
    end else begin
      return INTALU;
    end
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-queue free-slot counter: decrements on dispatch, increments on return,
// reloads to full on flush, flags a return that would overflow.
module credit_counter
  import dispatch_pkg::*;
#(
  parameter int W     = CW,
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         reload,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         err
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (reload) begin
      cnt_d = FULL;
    end else if (inc && !dec) begin
      if (cnt_q == FULL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// Dispatch flow control: pops the IFQ head only when its target issue queue
// has a credit, and drives the matching enq strobe one cycle later.
//
// state    | meaning
// ST_RUN   | dispatching normally
// ST_STALL | head valid but blocked (no credit or external hold)
// ST_FLUSH | dispatch held off for FLUSH_CYC cycles after a flush
module dispatch_credit_ctrl
  import dispatch_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          ifq_empty,
  input  logic [6:0]    ifq_opcode,
  input  logic          stall_ext,
  input  logic          flush,
  input  logic          ret_intalu,
  input  logic          ret_fpalu,
  input  logic          ret_agu,
  output logic          deq_ifq,
  output logic          enq_intalu,
  output logic          enq_fpalu,
  output logic          enq_agu,
  output logic [1:0]    q_sel,
  output logic [CW-1:0] cred_intalu,
  output logic [CW-1:0] cred_fpalu,
  output logic [CW-1:0] cred_agu,
  output logic [15:0]   stall_cycles,
  output logic          credit_err
);

  state_e              state_q, state_d;
  logic [FLUSH_CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [15:0]         stall_q, stall_d;
  logic                enq_int_q, enq_fp_q, enq_agu_q;
  logic                enq_int_d, enq_fp_d, enq_agu_d;
  logic [CW-1:0]       cred_sel;
  logic                head_valid;
  logic                err_int, err_fp, err_agu;

  assign q_sel      = classify_op(ifq_opcode);
  assign head_valid = !ifq_empty;

  always_comb begin
    case (q_sel)
      FPALU:   cred_sel = cred_fpalu;
      AGU:     cred_sel = cred_agu;
      default: cred_sel = cred_intalu;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      stall_q     <= '0;
      enq_int_q   <= 1'b0;
      enq_fp_q    <= 1'b0;
      enq_agu_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_q     <= stall_d;
      enq_int_q   <= enq_int_d;
      enq_fp_q    <= enq_fp_d;
      enq_agu_q   <= enq_agu_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      // a flush while already flushing restarts the hold-off
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_CW'(FLUSH_CYC - 1);
    end else begin
      case (state_q)
        ST_RUN:   if (head_valid && !deq_ifq) state_d = ST_STALL;
        ST_STALL: if (deq_ifq) state_d = ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    deq_ifq   = (state_q != ST_FLUSH) && head_valid && !stall_ext && !flush &&
                (cred_sel != '0);
    enq_int_d = deq_ifq && (q_sel == INTALU);
    enq_fp_d  = deq_ifq && (q_sel == FPALU);
    enq_agu_d = deq_ifq && (q_sel == AGU);
    stall_d   = stall_q;
    if ((state_q != ST_FLUSH) && head_valid && !deq_ifq && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  credit_counter u_cred_intalu (
    .clk    (clk),
    .resetn (resetn),
    .reload (flush),
    .dec    (deq_ifq && (q_sel == INTALU)),
    .inc    (ret_intalu),
    .cnt    (cred_intalu),
    .err    (err_int)
  );

  credit_counter u_cred_fpalu (
    .clk    (clk),
    .resetn (resetn),
    .reload (flush),
    .dec    (deq_ifq && (q_sel == FPALU)),
    .inc    (ret_fpalu),
    .cnt    (cred_fpalu),
    .err    (err_fp)
  );

  credit_counter u_cred_agu (
    .clk    (clk),
    .resetn (resetn),
    .reload (flush),
    .dec    (deq_ifq && (q_sel == AGU)),
    .inc    (ret_agu),
    .cnt    (cred_agu),
    .err    (err_agu)
  );

  assign enq_intalu   = enq_int_q;
  assign enq_fpalu    = enq_fp_q;
  assign enq_agu      = enq_agu_q;
  assign stall_cycles = stall_q;
  assign credit_err   = err_int | err_fp | err_agu;

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Self-checking bench for dispatch_credit_ctrl: classification vector table,
// then scoreboarded multi-cycle sequences for credits, flush, stall and reset.
module tb_dispatch_credit_ctrl;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_FLW  = 7'b0000111;
  localparam logic [6:0] OP_FADD = 7'b1010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifq_empty;
  logic [6:0]  ifq_opcode;
  logic        stall_ext;
  logic        flush;
  logic        ret_intalu, ret_fpalu, ret_agu;
  logic        deq_ifq;
  logic        enq_intalu, enq_fpalu, enq_agu;
  logic [1:0]  q_sel;
  logic [3:0]  cred_intalu, cred_fpalu, cred_agu;
  logic [15:0] stall_cycles;
  logic        credit_err;

  int passed = 0;
  int total  = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [6:0] op;
    logic       empty;
    logic       stall;
    logic [1:0] exp_sel;
    logic       exp_deq;
  } vec_t;
  vec_t vecs[8];

  dispatch_credit_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .ifq_empty    (ifq_empty),
    .ifq_opcode   (ifq_opcode),
    .stall_ext    (stall_ext),
    .flush        (flush),
    .ret_intalu   (ret_intalu),
    .ret_fpalu    (ret_fpalu),
    .ret_agu      (ret_agu),
    .deq_ifq      (deq_ifq),
    .enq_intalu   (enq_intalu),
    .enq_fpalu    (enq_fpalu),
    .enq_agu      (enq_agu),
    .q_sel        (q_sel),
    .cred_intalu  (cred_intalu),
    .cred_fpalu   (cred_fpalu),
    .cred_agu     (cred_agu),
    .stall_cycles (stall_cycles),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_class(input logic [6:0] op);
    casez (op)
      7'b10?????: return 2'b01;
      7'b0?0????: return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic idle();
    ifq_empty  = 1'b1;
    ifq_opcode = OP_ADD;
    stall_ext  = 1'b0;
    flush      = 1'b0;
    ret_intalu = 1'b0;
    ret_fpalu  = 1'b0;
    ret_agu    = 1'b0;
  endtask

  // one cycle: drive, check deq/q_sel, push expected enq, check it after the edge
  task automatic step(input logic e, input logic [6:0] op, input logic st, input logic fl,
                      input logic ri, input logic rf, input logic ra, input logic exp_deq);
    logic [1:0] cls;
    logic [2:0] exp_enq, got;
    @(negedge clk);
    ifq_empty = e; ifq_opcode = op; stall_ext = st; flush = fl;
    ret_intalu = ri; ret_fpalu = rf; ret_agu = ra;
    #1;
    cls = ref_class(op);
    chk("deq_ifq", int'(deq_ifq), int'(exp_deq));
    chk("q_sel", int'(q_sel), int'(cls));
    exp_enq = 3'b000;
    if (exp_deq) exp_enq = (cls == 2'b01) ? 3'b010 : (cls == 2'b10) ? 3'b001 : 3'b100;
    exp_q.push_back(exp_enq);
    @(posedge clk);
    #1;
    idle();
    got = {enq_intalu, enq_fpalu, enq_agu};
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL enq_scoreboard: got %b with nothing expected", got);
    end else begin
      chk("enq", int'(got), int'(exp_q.pop_front()));
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cred_intalu", int'(cred_intalu), 8);
    chk("rst_cred_fpalu", int'(cred_fpalu), 8);
    chk("rst_cred_agu", int'(cred_agu), 8);
    chk("rst_stall_cycles", int'(stall_cycles), 0);
    chk("rst_credit_err", int'(credit_err), 0);
    chk("rst_enq", int'({enq_intalu, enq_fpalu, enq_agu}), 0);
  endtask

  initial begin
    vecs[0] = '{OP_ADD,     1'b0, 1'b0, 2'b00, 1'b1};
    vecs[1] = '{OP_FADD,    1'b0, 1'b0, 2'b01, 1'b1};
    vecs[2] = '{OP_FLW,     1'b0, 1'b0, 2'b10, 1'b1};
    vecs[3] = '{OP_LW,      1'b0, 1'b1, 2'b10, 1'b0};
    vecs[4] = '{OP_ADDI,    1'b1, 1'b0, 2'b00, 1'b0};
    vecs[5] = '{7'b1100011, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[6] = '{7'b0100011, 1'b0, 1'b0, 2'b10, 1'b1};
    vecs[7] = '{7'b1110011, 1'b0, 1'b1, 2'b00, 1'b0};

    resetn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    resetn = 1'b1;

    // combinational classification / dispatch gating, restored before each edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifq_empty = vecs[i].empty; ifq_opcode = vecs[i].op; stall_ext = vecs[i].stall;
      #1;
      chk("vec_q_sel", int'(q_sel), int'(vecs[i].exp_sel));
      chk("vec_deq", int'(deq_ifq), int'(vecs[i].exp_deq));
      #1;
      idle();
    end

    // 8 ADDs drain INTALU credits, the 9th stalls
    for (int i = 0; i < 8; i++) begin
      step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("cred_intalu_drain", int'(cred_intalu), 7 - i);
    end
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cred_intalu_empty", int'(cred_intalu), 0);
    chk("stall_after_9th", int'(stall_cycles), 1);

    // return is not bypassed: usable the following cycle
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cred_intalu_ret", int'(cred_intalu), 1);
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cred_intalu_reuse", int'(cred_intalu), 0);

    // mixed back-to-back dispatch to all three queues
    step(1'b0, OP_FLW,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_FADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, OP_ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mixed_cred_agu", int'(cred_agu), 7);
    chk("mixed_cred_fpalu", int'(cred_fpalu), 7);
    chk("mixed_cred_intalu", int'(cred_intalu), 0);

    // simultaneous dispatch and return on AGU
    for (int i = 0; i < 4; i++) step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cred_agu_3", int'(cred_agu), 3);
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cred_agu_same", int'(cred_agu), 3);

    // overflow return sets the sticky error
    step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cred_fpalu_full", int'(cred_fpalu), 8);
    chk("credit_err_clear", int'(credit_err), 0);
    step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cred_fpalu_sat", int'(cred_fpalu), 8);
    chk("credit_err_set", int'(credit_err), 1);

    // external hold for 5 cycles with a dispatchable head
    for (int i = 0; i < 5; i++) step(1'b0, OP_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_ext_count", int'(stall_cycles), 7);
    chk("stall_ext_cred", int'(cred_agu), 3);
    step(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_release_count", int'(stall_cycles), 7);
    chk("stall_release_cred", int'(cred_agu), 2);

    // flush with cred_intalu=2; same-cycle returns ignored
    step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_cred", int'(cred_intalu), 2);
    step(1'b1, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_cred_intalu", int'(cred_intalu), 8);
    chk("flush_cred_fpalu", int'(cred_fpalu), 8);
    chk("flush_cred_agu", int'(cred_agu), 8);
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_hold_cred", int'(cred_intalu), 8);
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_flush_cred", int'(cred_intalu), 7);
    chk("err_sticky_flush", int'(credit_err), 1);

    // asynchronous reset while stalled
    step(1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_reset_vals();
    #2;
    resetn = 1'b1;
    step(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_reset_cred", int'(cred_intalu), 7);

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
